// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: traffic-light FSM (GREEN, YELLOW, RED, WALK) timed by the
// 7->0 wrap of an upstream 3-bit free-running counter. It latches pedestrian
// requests, acknowledges them on entry to WALK, and can cut GREEN short once
// GREEN_MIN ticks have elapsed.
// Optional build macro FLASH_MODE_EN adds a night_mode input. Night mode holds
// the FSM in a flashing YELLOW and exits through RED.
module traffic_light_ctrl #(
    parameter int GREEN_TICKS  = 4,
    parameter int GREEN_MIN    = 2,
    parameter int YELLOW_TICKS = 1,
    parameter int RED_TICKS    = 3,
    parameter int WALK_TICKS   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] count,
    input  logic       ped_req,
`ifdef FLASH_MODE_EN
    input  logic       night_mode,
`endif
    output logic [2:0] light,
    output logic       walk,
    output logic       ped_ack,
    output logic [1:0] state,
    output logic       tick_o
);

    localparam logic [1:0] ST_GREEN  = 2'd0;
    localparam logic [1:0] ST_YELLOW = 2'd1;
    localparam logic [1:0] ST_RED    = 2'd2;
    localparam logic [1:0] ST_WALK   = 2'd3;

    // Last dwell value of each phase, so that a phase lasts exactly N ticks.
    localparam logic [3:0] GREEN_LAST  = 4'(GREEN_TICKS - 1);
    localparam logic [3:0] GREEN_CUT   = 4'(GREEN_MIN - 1);
    localparam logic [3:0] YELLOW_LAST = 4'(YELLOW_TICKS - 1);
    localparam logic [3:0] RED_LAST    = 4'(RED_TICKS - 1);
    localparam logic [3:0] WALK_LAST   = 4'(WALK_TICKS - 1);

    // One-hot {red, yellow, green} lamp pattern shown in a given state.
    function automatic logic [2:0] light_of(input logic [1:0] st);
        logic [2:0] l;
        case (st)
            ST_GREEN:  l = 3'b001;
            ST_YELLOW: l = 3'b010;
            default:   l = 3'b100;
        endcase
        return l;
    endfunction

    logic [1:0] state_r;
    logic [3:0] dwell_r;
    logic       ped_pending_r;
    logic [2:0] prev_count_r;
    logic [2:0] light_r;
    logic       walk_r;
    logic       ped_ack_r;
    logic       tick_r;

    logic       tick_s;
    logic [1:0] fsm_next_s;
    logic       fsm_serve_s;
    logic [1:0] next_state_s;
    logic       serve_s;
    logic       dwell_clr_s;
    logic [2:0] light_next_s;

`ifdef FLASH_MODE_EN
    logic       night_r;
    logic       flash_r;
    logic       yel_s;
`endif

    // Only a genuine 7->0 wrap of the counter counts as a tick.
    assign tick_s = (prev_count_r == 3'd7) && (count == 3'd0);

    // Normal-mode phase sequencing. Moves happen only on a tick.
    always_comb begin
        fsm_next_s  = state_r;
        fsm_serve_s = 1'b0;
        if (tick_s) begin
            case (state_r)
                ST_GREEN: begin
                    if ((dwell_r == GREEN_LAST) || (ped_pending_r && (dwell_r >= GREEN_CUT))) begin
                        fsm_next_s = ST_YELLOW;
                    end else begin
                        fsm_next_s = ST_GREEN;
                    end
                end
                ST_YELLOW: begin
                    if (dwell_r == YELLOW_LAST) begin
                        fsm_next_s = ST_RED;
                    end else begin
                        fsm_next_s = ST_YELLOW;
                    end
                end
                ST_RED: begin
                    if (dwell_r == RED_LAST) begin
                        if (ped_pending_r) begin
                            fsm_next_s  = ST_WALK;
                            fsm_serve_s = 1'b1;
                        end else begin
                            fsm_next_s = ST_GREEN;
                        end
                    end else begin
                        fsm_next_s = ST_RED;
                    end
                end
                ST_WALK: begin
                    if (dwell_r == WALK_LAST) begin
                        fsm_next_s = ST_GREEN;
                    end else begin
                        fsm_next_s = ST_WALK;
                    end
                end
                default: fsm_next_s = ST_RED;
            endcase
        end else begin
            fsm_next_s = state_r;
        end
    end

`ifdef FLASH_MODE_EN
    // Night mode overrides the FSM: hold YELLOW, then leave through RED.
    always_comb begin
        next_state_s = fsm_next_s;
        serve_s      = fsm_serve_s;
        dwell_clr_s  = 1'b0;
        yel_s        = 1'b1;
        light_next_s = light_of(fsm_next_s);
        if (night_mode) begin
            next_state_s = ST_YELLOW;
            serve_s      = 1'b0;
            dwell_clr_s  = 1'b1;
            yel_s        = night_r ? (tick_s ? ~flash_r : flash_r) : 1'b1;
            light_next_s = {1'b0, yel_s, 1'b0};
        end else if (night_r) begin
            next_state_s = ST_RED;
            serve_s      = 1'b0;
            dwell_clr_s  = 1'b1;
            light_next_s = light_of(ST_RED);
        end else begin
            dwell_clr_s  = (fsm_next_s != state_r);
        end
    end

    // Night-mode history and the current yellow flash phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            night_r <= 1'b0;
            flash_r <= 1'b1;
        end else begin
            night_r <= night_mode;
            if (night_mode) begin
                flash_r <= yel_s;
            end else begin
                flash_r <= 1'b1;
            end
        end
    end
`else
    // Without night mode, the normal FSM decides everything.
    always_comb begin
        next_state_s = fsm_next_s;
        serve_s      = fsm_serve_s;
        dwell_clr_s  = (fsm_next_s != state_r);
        light_next_s = light_of(fsm_next_s);
    end
`endif

    // State, dwell, request latch and counter history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_RED;
            dwell_r       <= 4'd0;
            ped_pending_r <= 1'b0;
            prev_count_r  <= 3'd0;
        end else begin
            state_r      <= next_state_s;
            prev_count_r <= count;
            if (dwell_clr_s) begin
                dwell_r <= 4'd0;
            end else if (tick_s) begin
                dwell_r <= dwell_r + 4'd1;
            end else begin
                dwell_r <= dwell_r;
            end
            // A new request on the serving edge wins over the clear.
            if (ped_req) begin
                ped_pending_r <= 1'b1;
            end else if (serve_s) begin
                ped_pending_r <= 1'b0;
            end else begin
                ped_pending_r <= ped_pending_r;
            end
        end
    end

    // Outputs decoded from the next state, so lamps change with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            light_r   <= 3'b100;
            walk_r    <= 1'b0;
            ped_ack_r <= 1'b0;
            tick_r    <= 1'b0;
        end else begin
            light_r   <= light_next_s;
            walk_r    <= (next_state_s == ST_WALK);
            ped_ack_r <= serve_s;
            tick_r    <= tick_s;
        end
    end

    assign light   = light_r;
    assign walk    = walk_r;
    assign ped_ack = ped_ack_r;
    assign state   = state_r;
    assign tick_o  = tick_r;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Randomized bench for traffic_light_ctrl against a phase/tick-count model.
module tb_traffic_light_ctrl;

    localparam int GT = 4;
    localparam int GM = 2;
    localparam int YT = 1;
    localparam int RT = 3;
    localparam int WT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] count = 3'd0;
    logic       ped_req = 1'b0;
`ifdef FLASH_MODE_EN
    logic       night_mode = 1'b0;
`endif
    logic [2:0] light;
    logic       walk;
    logic       ped_ack;
    logic [1:0] state;
    logic       tick_o;

    traffic_light_ctrl #(
        .GREEN_TICKS(GT), .GREEN_MIN(GM), .YELLOW_TICKS(YT),
        .RED_TICKS(RT), .WALK_TICKS(WT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .count(count),
        .ped_req(ped_req),
`ifdef FLASH_MODE_EN
        .night_mode(night_mode),
`endif
        .light(light),
        .walk(walk),
        .ped_ack(ped_ack),
        .state(state),
        .tick_o(tick_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: phase name, ticks elapsed in the phase, request latch, last count.
    int m_state, m_elapsed, m_pend, m_prev, m_ack, m_tick;
    int acks_seen = 0;
    int ticks_seen = 0;
    int walks_seen = 0;
    int did_rst = 0;

    function automatic int phase_len(input int s);
        case (s)
            0: return GT;
            1: return YT;
            2: return RT;
            default: return WT;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 2; m_elapsed = 0; m_pend = 0; m_prev = 0; m_ack = 0; m_tick = 0;
    endtask

    task automatic model_step(input int cnt, input int req);
        int serve;
        serve  = 0;
        m_tick = (m_prev == 7 && cnt == 0) ? 1 : 0;
        m_prev = cnt;
        if (m_tick == 1) begin
            m_elapsed++;
            if (m_state == 0 && (m_elapsed == phase_len(0) || (m_pend == 1 && m_elapsed >= GM))) begin
                m_state = 1; m_elapsed = 0;
            end else if (m_state == 1 && m_elapsed == phase_len(1)) begin
                m_state = 2; m_elapsed = 0;
            end else if (m_state == 2 && m_elapsed == phase_len(2)) begin
                m_state = (m_pend == 1) ? 3 : 0;
                serve   = m_pend;
                m_elapsed = 0;
            end else if (m_state == 3 && m_elapsed == phase_len(3)) begin
                m_state = 0; m_elapsed = 0;
            end
        end
        m_ack = serve;
        if (req == 1) m_pend = 1;
        else if (serve == 1) m_pend = 0;
    endtask

    task automatic check_all(input string where);
        int exp_light;
        exp_light = (m_state == 0) ? 1 : (m_state == 1) ? 2 : 4;
        check_eq({where, ".state"},  state,   m_state);
        check_eq({where, ".light"},  light,   exp_light);
        check_eq({where, ".walk"},   walk,    (m_state == 3) ? 1 : 0);
        check_eq({where, ".ped_ack"}, ped_ack, m_ack);
        check_eq({where, ".tick_o"}, tick_o,  m_tick);
        check_eq({where, ".onehot"}, $onehot(light), 1);
    endtask

    initial begin
        int quiet_until;
        int r;
        quiet_until = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst = 1'b1;
        for (int cyc = 0; cyc < 2400; cyc++) begin
            model_step(int'(count), int'(ped_req));
            @(negedge clk);
            check_all("run");
            if (m_ack == 1) acks_seen++;
            if (m_tick == 1) ticks_seen++;
            if (m_state == 3) walks_seen++;
            // Asynchronous reset in YELLOW with a request pending.
            if (did_rst == 0 && cyc >= 900 && m_state == 1 && m_pend == 1) begin
                ped_req = 1'b0;
                rst = 1'b0;
                #1;
                model_reset();
                check_all("rst_async");
                @(negedge clk);
                check_all("rst_hold");
                rst = 1'b1;
                did_rst = 1;
                quiet_until = cyc + 400;
            end
            // Counter mostly free-runs, with occasional non-wrap jumps.
            r = $urandom_range(0, 39);
            if (count == 3'd3 && r < 4) count = 3'd0;
            else if (count == 3'd7 && r < 4) count = 3'd5;
            else if (r == 5) count = 3'($urandom_range(0, 7));
            else count = count + 3'd1;
            // Requests: quiet start, random pulses, a long held level.
            if (cyc < 150 || cyc < quiet_until) ped_req = 1'b0;
            else if (cyc >= 600 && cyc < 900) ped_req = 1'b1;
            else ped_req = ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0;
        end
        check_eq("reset_exercised", did_rst, 1);
        check_eq("acks_exercised", (acks_seen > 1) ? 1 : 0, 1);
        check_eq("walk_exercised", (walks_seen > 0) ? 1 : 0, 1);
        check_eq("ticks_exercised", (ticks_seen > 50) ? 1 : 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
